// File: rtl/avmm_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avmm_pkg
// Purpose  : Shared constants, state encoding and LFSR helper for the
//            Avalon-MM memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package avmm_pkg;

    localparam int          AVMM_DW   = 16;
    localparam logic [15:0] OOR_DATA  = 16'hDEAD;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        ACCEPT = 2'd2
    } state_t;

    // One step of the stall-randomising LFSR: shift left, feed back the tap parity
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/avmm_mem_responder_read_pipe.sv
`default_nettype none
// ============================================================================
// Module   : avmm_read_pipe
// Purpose  : Fixed-latency read return pipe. Each stage carries a valid bit
//            and a data word; only the valid bits are reset so a reset
//            discards every read in flight.
// Revision : 1.0 - initial release
// ============================================================================
module avmm_read_pipe #(
    parameter int READ_LAT = 2,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [READ_LAT-1:0] r_valid;
    logic [DW-1:0]       r_data [READ_LAT];

    // Valid bits shift one stage per cycle and are cleared by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= in_valid;
            for (int i = 1; i < READ_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Data words follow the valid bits; they need no reset because the output is qualified
    always_ff @(posedge clk) begin
        r_data[0] <= in_data;
        for (int i = 1; i < READ_LAT; i++) begin
            r_data[i] <= r_data[i-1];
        end
    end

    assign out_valid = r_valid[READ_LAT-1];
    assign out_data  = r_data[READ_LAT-1];

endmodule
`default_nettype wire

// File: rtl/avmm_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : avmm_mem_responder
// Purpose  : Avalon-MM 16-bit responder holding a word-addressed on-chip
//            memory window. Commands are stalled with waitrequest for a
//            configurable number of cycles; reads return with a fixed
//            pipelined latency. Optional build macro AVMM_RESP_RANDSTALL_EN
//            adds 0..3 pseudo-random stall cycles per command.
// Revision : 1.0 - initial release
// ============================================================================
module avmm_mem_responder
    import avmm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'd600_000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter int          READ_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] address,
    input  logic [1:0]  byteenable,
    input  logic [15:0] writedata,
    output logic        waitrequest,
    output logic [15:0] readdata,
    output logic        readdatavalid,
    output logic        err
);

    localparam int          c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_SPAN  = 33'(2 * DEPTH_WORDS);

    state_t              r_state;
    logic [4:0]          r_stall_cnt;
    logic                r_err;
    logic [AVMM_DW-1:0]  r_mem [DEPTH_WORDS];

    logic                w_cmd;
    logic                w_rd;
    logic                w_wr;
    logic                w_both;
    logic [1:0]          w_extra;
    logic [4:0]          w_limit;
    logic                w_waitrequest;
    logic                w_accept;
    logic [31:0]         w_offset;
    logic                w_in_range;
    logic [c_IDX_W-1:0]  w_index;
    logic [AVMM_DW-1:0]  w_rd_data;
    logic [AVMM_DW-1:0]  w_pipe_data;

    assign w_cmd  = chipselect & (~read_n | ~write_n);
    assign w_rd   = ~read_n &  write_n;
    assign w_wr   =  read_n & ~write_n;
    assign w_both = ~read_n & ~write_n;

`ifdef AVMM_RESP_RANDSTALL_EN
    logic [15:0] r_lfsr;

    // LFSR steps once per accepted command so each command sees a fresh extra stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_accept) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_extra = r_lfsr[1:0];
`else
    assign w_extra = 2'd0;
`endif

    assign w_limit       = 5'(WAIT_CYCLES) + {3'b000, w_extra};
    // Held high through reset so no master can be accepted while the responder is down
    assign w_waitrequest = ~reset_n | (w_cmd & (r_stall_cnt < w_limit));
    assign w_accept      = w_cmd & ~w_waitrequest;

    // Window decode: the offset comparison is only meaningful at or above the base
    assign w_offset   = address - BASE_ADDR;
    assign w_in_range = (address >= BASE_ADDR) && ({1'b0, w_offset} < c_SPAN);
    assign w_index    = w_offset[c_IDX_W:1];

    // Stall tracking: a stall that follows any non-stall cycle restarts the count at one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_stall_cnt <= 5'd0;
        end else if (!w_cmd) begin
            r_state     <= IDLE;
            r_stall_cnt <= 5'd0;
        end else if (w_waitrequest) begin
            r_state     <= STALL;
            r_stall_cnt <= (r_state == STALL) ? r_stall_cnt + 5'd1 : 5'd1;
        end else begin
            r_state     <= ACCEPT;
            r_stall_cnt <= 5'd0;
        end
    end

    // Byte-lane write of the memory window; contents survive reset
    always_ff @(posedge clk) begin
        if (w_accept && w_wr && w_in_range) begin
            if (byteenable[0]) r_mem[w_index][7:0]  <= writedata[7:0];
            if (byteenable[1]) r_mem[w_index][15:8] <= writedata[15:8];
        end
    end

    // Sticky error: any accepted out-of-window access or read+write collision
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_accept && (w_both || !w_in_range)) begin
            r_err <= 1'b1;
        end
    end

    // Read data is captured at the accept edge, so a write accepted one cycle earlier is visible
    assign w_rd_data = w_in_range ? r_mem[w_index] : OOR_DATA;

    avmm_read_pipe #(
        .READ_LAT (READ_LAT),
        .DW       (AVMM_DW)
    ) u_read_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (w_accept & w_rd),
        .in_data   (w_rd_data),
        .out_valid (readdatavalid),
        .out_data  (w_pipe_data)
    );

    assign readdata    = readdatavalid ? w_pipe_data : '0;
    assign waitrequest = w_waitrequest;
    assign err         = r_err;

endmodule
`default_nettype wire
